// File: rtl/branch_resolver.sv
// Branch predictor lookup (BHT + BTB) with misprediction detection and a one-cycle flush/redirect.
// Define BRANCH_RESOLVER_BTB_EN for dynamic prediction; left undefined the block is a static not-taken predictor.
module branch_resolver #(
    parameter int BHT_INDEX_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Lookup_PC_IN,
    output logic        Pred_Taken_OUT,
    output logic [31:0] Pred_Target_OUT,
    output logic [1:0]  Pred_Counter_OUT,
    input  logic        STALL,
    input  logic        Resolve_VALID_IN,
    input  logic [31:0] Resolve_PC_IN,
    input  logic [31:0] Resolve_PC_Plus4_IN,
    input  logic        Resolve_Taken_IN,
    input  logic [31:0] Resolve_Target_IN,
    input  logic        Resolve_Pred_Taken_IN,
    input  logic [31:0] Resolve_Pred_Addr_IN,
    input  logic [1:0]  Resolve_Pred_Counter_IN,
    output logic        FLUSH_OUT,
    output logic [31:0] Redirect_PC_OUT,
    output logic [31:0] Mispredict_Count_OUT
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] count_q, count_d;
    logic        accept;
    logic        mispredict;
    logic [31:0] correct_pc;

    // The instruction sitting in ID while we flush is wrong-path, so it is never consumed.
    assign accept     = Resolve_VALID_IN && !STALL && (state_q == ST_IDLE);
    assign correct_pc = Resolve_Taken_IN ? Resolve_Target_IN : Resolve_PC_Plus4_IN;

    assign FLUSH_OUT            = (state_q == ST_FLUSH);
    assign Redirect_PC_OUT      = redirect_q;
    assign Mispredict_Count_OUT = count_q;

`ifdef BRANCH_RESOLVER_BTB_EN
    localparam int ENTRIES  = 1 << BHT_INDEX_BITS;
    localparam int TAG_LSB  = BHT_INDEX_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;

    logic [1:0]          bht_q        [ENTRIES];
    logic [1:0]          bht_d        [ENTRIES];
    logic                btb_valid_q  [ENTRIES];
    logic                btb_valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_d    [ENTRIES];
    logic [31:0]         btb_target_q [ENTRIES];
    logic [31:0]         btb_target_d [ENTRIES];

    logic [BHT_INDEX_BITS-1:0] lookup_idx;
    logic [BHT_INDEX_BITS-1:0] resolve_idx;
    logic                      lookup_hit;
    logic                      unused_pc_bits;

    assign lookup_idx     = Lookup_PC_IN[TAG_LSB-1:2];
    assign resolve_idx    = Resolve_PC_IN[TAG_LSB-1:2];
    assign unused_pc_bits = ^Resolve_PC_IN[1:0];

    assign lookup_hit = btb_valid_q[lookup_idx]
                        && (btb_tag_q[lookup_idx] == Lookup_PC_IN[31:TAG_LSB]);

    assign Pred_Counter_OUT = bht_q[lookup_idx];
    assign Pred_Taken_OUT   = lookup_hit && bht_q[lookup_idx][1];
    assign Pred_Target_OUT  = Pred_Taken_OUT ? btb_target_q[lookup_idx] : Lookup_PC_IN + 32'd4;

    assign mispredict = (Resolve_Taken_IN != Resolve_Pred_Taken_IN)
                        || (Resolve_Taken_IN && Resolve_Pred_Taken_IN
                            && (Resolve_Target_IN != Resolve_Pred_Addr_IN));

    // The new counter comes from the value IF carried down, not from a second table read.
    always_comb begin
        bht_d        = bht_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (accept) begin
            if (Resolve_Taken_IN) begin
                bht_d[resolve_idx]        = (Resolve_Pred_Counter_IN == 2'b11)
                                            ? 2'b11 : Resolve_Pred_Counter_IN + 2'b01;
                btb_valid_d[resolve_idx]  = 1'b1;
                btb_tag_d[resolve_idx]    = Resolve_PC_IN[31:TAG_LSB];
                btb_target_d[resolve_idx] = Resolve_Target_IN;
            end else begin
                bht_d[resolve_idx]        = (Resolve_Pred_Counter_IN == 2'b00)
                                            ? 2'b00 : Resolve_Pred_Counter_IN - 2'b01;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i]       <= 2'b01;
                btb_valid_q[i] <= 1'b0;
            end
        end else begin
            bht_q       <= bht_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // Tag and target are only observed through a set valid bit, so they need no reset.
    always_ff @(posedge CLK) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
    end
`else
    logic [BHT_INDEX_BITS-1:0] unused_resolve_idx;
    logic                      unused_resolve;

    assign unused_resolve_idx = Resolve_PC_IN[BHT_INDEX_BITS+1:2];
    assign unused_resolve     = ^{Resolve_PC_IN, Resolve_Pred_Addr_IN, Resolve_Pred_Counter_IN};

    assign Pred_Taken_OUT   = 1'b0;
    assign Pred_Target_OUT  = Lookup_PC_IN + 32'd4;
    assign Pred_Counter_OUT = 2'b01;

    // A stale taken prediction still needs recovery back to the fall-through PC.
    assign mispredict = Resolve_Taken_IN || Resolve_Pred_Taken_IN;
`endif

    always_comb begin
        state_d    = ST_IDLE;
        redirect_d = redirect_q;
        count_d    = count_q;
        if (accept && mispredict) begin
            state_d    = ST_FLUSH;
            redirect_d = correct_pc;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            redirect_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Closes the branch-prediction loop for the IF→ID pipeline. IF looks up a prediction here for each fetch. The IF/ID register carries the taken bit, predicted address and 2-bit counter to ID. ID then presents the actual outcome back to this block. The block detects mispredictions, issues a one-cycle FLUSH and redirect PC to fetch and the IF/ID register, and updates its branch history table (BHT) and branch target buffer (BTB).

## Interface
- `BHT_INDEX_BITS`, default 6: table depth is 2^6 = 64 entries; index = PC[7:2].
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-low.
- `Lookup_PC_IN` in 32: fetch PC from IF.
- `Pred_Taken_OUT` out 1: predicted taken, combinational.
- `Pred_Target_OUT` out 32: predicted next PC, combinational.
- `Pred_Counter_OUT` out 2: BHT counter read for `Lookup_PC_IN`.
- `STALL` in 1: pipeline frozen; resolve inputs not consumed.
- `Resolve_VALID_IN` in 1: ID presents a resolved control-flow instruction.
- `Resolve_PC_IN`, `Resolve_PC_Plus4_IN` in 32: PC and PC+4 of that instruction.
- `Resolve_Taken_IN` in 1: actual direction.
- `Resolve_Target_IN` in 32: actual target, meaningful when taken.
- `Resolve_Pred_Taken_IN` in 1: prediction carried through IF/ID.
- `Resolve_Pred_Addr_IN` in 32: predicted address carried through IF/ID.
- `Resolve_Pred_Counter_IN` in 2: counter carried through IF/ID.
- `FLUSH_OUT` out 1: registered one-cycle pulse; clears the IF/ID register.
- `Redirect_PC_OUT` out 32: correct next PC, valid while `FLUSH_OUT`=1.
- `Mispredict_Count_OUT` out 32: saturating misprediction counter.

## Operation
- Accept condition: `Resolve_VALID_IN` && !`STALL` && !`FLUSH_OUT`. While `FLUSH_OUT`=1, the instruction in ID is wrong-path, so the block ignores it.
- Mispredict when either condition holds:
  - (`Resolve_Taken_IN` != `Resolve_Pred_Taken_IN`)
  - (`Resolve_Taken_IN` && `Resolve_Pred_Taken_IN` && `Resolve_Target_IN` != `Resolve_Pred_Addr_IN`)
- Correct PC: taken ? `Resolve_Target_IN` : `Resolve_PC_Plus4_IN`.
- BHT update on every accepted resolve, computed from `Resolve_Pred_Counter_IN` and never re-read from the table:
  - Taken: min(c+1, 3).
  - Not taken: max(c−1, 0).
  - Written at index `Resolve_PC_IN[7:2]`.
- BTB update on accepted taken resolves: entry[index] ← {valid=1, tag=`Resolve_PC_IN[31:8]`, target=`Resolve_Target_IN`}. Not-taken resolves leave the BTB unchanged.
- Lookup:
  - hit = BTB valid && tag match.
  - `Pred_Taken_OUT` = hit && counter[1].
  - `Pred_Target_OUT` = `Pred_Taken_OUT` ? BTB target : `Lookup_PC_IN`+4.
- `Mispredict_Count_OUT` increments on each accepted mispredict and holds at 32'hFFFFFFFF.
- Flush state machine:
  - IDLE → FLUSH on an accepted mispredict: `FLUSH_OUT`=1, `Redirect_PC_OUT` = correct PC.
  - FLUSH → IDLE unconditionally the next cycle. Back-to-back flushes are therefore impossible.

## Timing
- Reset values:
  - `FLUSH_OUT`=0, `Redirect_PC_OUT`=0, `Mispredict_Count_OUT`=0, state IDLE.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0, so `Pred_Taken_OUT`=0 after reset.
- Lookup is combinational, zero cycles. IF registers the result alongside the instruction.
- Resolve-to-flush latency is 1 cycle: mispredict accepted at edge N, `FLUSH_OUT` high from N to N+1.
- Table writes take effect at the accepting edge. A lookup of the same index in the same cycle returns the pre-update value.
- `STALL` high during a mispredicting resolve: the resolve is not accepted and there is no update. It is accepted on the first non-stalled cycle while still presented.
- Async `RESET` mid-FLUSH drops `FLUSH_OUT` immediately and reinitialises the tables.

## Configuration
- `BRANCH_RESOLVER_BTB_EN` defined: BTB and dynamic prediction behave as described above.
- Undefined: BTB is not instantiated and the block becomes a static not-taken predictor.
  - `Pred_Taken_OUT`=0.
  - `Pred_Target_OUT` = `Lookup_PC_IN`+4.
  - `Pred_Counter_OUT`=2'b01.
  - BHT is not updated.
  - Every accepted taken resolve is a mispredict, redirecting to `Resolve_Target_IN`.

## Test plan
- Reset, then look up `Lookup_PC_IN`=0x0040_0010: `Pred_Taken_OUT`=0, `Pred_Target_OUT`=0x0040_0014, `Pred_Counter_OUT`=01.
- Resolve PC 0x0040_0010, taken, target 0x0040_0100, pred 0, counter 01:
  - `FLUSH_OUT` pulses exactly 1 cycle; `Redirect_PC_OUT`=0x0040_0100; count=1.
  - Lookup then gives counter 10, taken, target 0x0040_0100.
- Two correct taken resolves from counter 10: no flush; counter reaches 11 and stays at 11 on a third.
- Pred taken to 0x0040_0100, actual taken to 0x0040_0200: flush with redirect 0x0040_0200.
- Mispredict presented with `STALL`=1 for 3 cycles, then `STALL`=0: no flush during the stall; flush one cycle after release.
- Mispredict immediately followed by another valid mispredict the next cycle: the second is ignored (`FLUSH_OUT` high), giving a single pulse. Assert `RESET` during a flush: `FLUSH_OUT`=0 immediately.
